// File: rtl/path_pkg.sv
// Shared move and tracker-state encodings for the maze path datapath.
// The maze solver FSM reuses the same move constants.
package path_pkg;

  localparam logic [1:0] MOVE_UP    = 2'b00;
  localparam logic [1:0] MOVE_RIGHT = 2'b01;
  localparam logic [1:0] MOVE_LEFT  = 2'b10;
  localparam logic [1:0] MOVE_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StTrack   = 2'b01,
    StArrived = 2'b10,
    StError   = 2'b11
  } track_state_e;

endpackage

// File: rtl/step_unit.sv
// Combinational single-step move decoder: next cell plus out-of-bounds flag.
// The edge check works at COORD_W+1 bits, so a carry/borrow into the top bit means off-grid.
module step_unit
  import path_pkg::*;
#(
  parameter int unsigned COORD_W = 4
) (
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic [1:0]         move,
  output logic [COORD_W-1:0] next_row,
  output logic [COORD_W-1:0] next_col,
  output logic               oob
);

  logic [COORD_W:0] row_ext;
  logic [COORD_W:0] col_ext;
  logic [COORD_W:0] row_sum;
  logic [COORD_W:0] col_sum;

  assign row_ext = {1'b0, row};
  assign col_ext = {1'b0, col};

  always_comb begin
    row_sum = row_ext;
    col_sum = col_ext;
    unique case (move)
      MOVE_UP:    row_sum = row_ext - 1'b1;
      MOVE_RIGHT: col_sum = col_ext + 1'b1;
      MOVE_LEFT:  col_sum = col_ext - 1'b1;
      MOVE_DOWN:  row_sum = row_ext + 1'b1;
      default:    ;
    endcase
  end

  assign oob      = row_sum[COORD_W] | col_sum[COORD_W];
  // Hold the cell on an illegal move so no wrapped value ever leaks out.
  assign next_row = oob ? row : row_sum[COORD_W-1:0];
  assign next_col = oob ? col : col_sum[COORD_W-1:0];

endmodule

// File: rtl/path_tracker.sv
// Replay-phase path tracker: applies accepted moves to a registered cell, counts steps,
// and flags goal arrival or an illegal path (off-grid, step overflow, short path).
module path_tracker
  import path_pkg::*;
#(
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned START_ROW = 0,
  parameter int unsigned START_COL = 0,
  parameter int unsigned GOAL_ROW  = 15,
  parameter int unsigned GOAL_COL  = 15,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               move_valid,
  input  logic [1:0]         move_in,
  input  logic               move_last,
  output logic               move_ready,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic [CNT_W-1:0]   step_cnt,
  output logic               busy,
  output logic               arrived,
  output logic               error
);

  localparam logic [COORD_W-1:0] StartRow = COORD_W'(START_ROW);
  localparam logic [COORD_W-1:0] StartCol = COORD_W'(START_COL);
  localparam logic [COORD_W-1:0] GoalRow  = COORD_W'(GOAL_ROW);
  localparam logic [COORD_W-1:0] GoalCol  = COORD_W'(GOAL_COL);

  track_state_e       state_q, state_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, arrived_q, error_q;

  logic [COORD_W-1:0] next_row;
  logic [COORD_W-1:0] next_col;
  logic               step_oob;
  logic               accept;
  logic               at_goal;

  step_unit #(
    .COORD_W (COORD_W)
  ) u_step_unit (
    .row      (row_q),
    .col      (col_q),
    .move     (move_in),
    .next_row (next_row),
    .next_col (next_col),
    .oob      (step_oob)
  );

  assign accept  = move_valid && (state_q == StTrack);
  assign at_goal = (next_row == GoalRow) && (next_col == GoalCol);

  // State and datapath registers; flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      row_q     <= StartRow;
      col_q     <= StartCol;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      arrived_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d == StTrack);
      arrived_q <= (state_d == StArrived);
      error_q   <= (state_d == StError);
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    if (start) begin
      // Restart from any state, and beats a move presented in the same cycle.
      state_d = StTrack;
      row_d   = StartRow;
      col_d   = StartCol;
      cnt_d   = '0;
    end else if (accept) begin
      if (step_oob || (&cnt_q)) begin
        state_d = StError;
      end else begin
        row_d = next_row;
        col_d = next_col;
        cnt_d = cnt_q + 1'b1;
        if (at_goal) begin
          state_d = StArrived;
        end else if (move_last) begin
          state_d = StError;
        end
      end
    end
  end

  always_comb begin
    move_ready = (state_q == StTrack);
    row        = row_q;
    col        = col_q;
    step_cnt   = cnt_q;
    busy       = busy_q;
    arrived    = arrived_q;
    error      = error_q;
  end

endmodule

// File: tb/tb_path_tracker.sv
// Directed self-checking bench for path_tracker; a second instance with a 3-bit counter
// covers step overflow.
module tb_path_tracker;
  import path_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       move_valid = 1'b0;
  logic [1:0] move_in = 2'b00;
  logic       move_last = 1'b0;

  logic       move_ready, busy, arrived, error;
  logic [3:0] row, col;
  logic [7:0] step_cnt;

  logic       ov_move_ready, ov_busy, ov_arrived, ov_error;
  logic [3:0] ov_row, ov_col;
  logic [2:0] ov_step_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  path_tracker dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .move_valid (move_valid),
    .move_in    (move_in),
    .move_last  (move_last),
    .move_ready (move_ready),
    .row        (row),
    .col        (col),
    .step_cnt   (step_cnt),
    .busy       (busy),
    .arrived    (arrived),
    .error      (error)
  );

  path_tracker #(
    .CNT_W (3)
  ) dut_ov (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .move_valid (move_valid),
    .move_in    (move_in),
    .move_last  (move_last),
    .move_ready (ov_move_ready),
    .row        (ov_row),
    .col        (ov_col),
    .step_cnt   (ov_step_cnt),
    .busy       (ov_busy),
    .arrived    (ov_arrived),
    .error      (ov_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Inputs change on the falling edge; outputs are read on the falling edge after.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic mv(input logic [1:0] m, input logic last);
    move_valid = 1'b1;
    move_in    = m;
    move_last  = last;
    @(negedge clk);
    move_valid = 1'b0;
    move_last  = 1'b0;
  endtask

  task automatic check_main(input string tag, input int r, input int c, input int n,
                            input logic b, input logic a, input logic e);
    check({tag, ".row"}, 32'(row), 32'(r));
    check({tag, ".col"}, 32'(col), 32'(c));
    check({tag, ".cnt"}, 32'(step_cnt), 32'(n));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".arrived"}, 32'(arrived), 32'(a));
    check({tag, ".error"}, 32'(error), 32'(e));
    check({tag, ".ready"}, 32'(move_ready), 32'(b));
  endtask

  initial begin
    @(negedge clk);
    // Reset then idle: moves presented with no start are ignored.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    move_valid = 1'b1;
    move_in    = MOVE_RIGHT;
    repeat (2) @(negedge clk);
    move_valid = 1'b0;
    check_main("idle", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Full legal path along the top row then down the right column.
    do_start();
    check_main("start", 0, 0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) mv(MOVE_RIGHT, 1'b0);
    check_main("right15", 0, 15, 15, 1'b1, 1'b0, 1'b0);
    check("right15.oob_guard", 32'(error), 32'd0);
    for (int i = 0; i < 14; i++) mv(MOVE_DOWN, 1'b0);
    mv(MOVE_DOWN, 1'b1);
    check_main("goal", 15, 15, 30, 1'b0, 1'b1, 1'b0);
    mv(MOVE_UP, 1'b0);
    check_main("goal_frozen", 15, 15, 30, 1'b0, 1'b1, 1'b0);

    // Off-grid move at the start corner.
    do_start();
    mv(MOVE_UP, 1'b0);
    check_main("oob_up", 0, 0, 0, 1'b0, 1'b0, 1'b1);
    mv(MOVE_RIGHT, 1'b0);
    check_main("oob_frozen", 0, 0, 0, 1'b0, 1'b0, 1'b1);

    // Left off the grid from column 0 after a down move.
    do_start();
    mv(MOVE_DOWN, 1'b0);
    mv(MOVE_LEFT, 1'b0);
    check_main("oob_left", 1, 0, 1, 1'b0, 1'b0, 1'b1);

    // Path ending short of the goal.
    do_start();
    check_main("restart_clears", 0, 0, 0, 1'b1, 1'b0, 1'b0);
    mv(MOVE_RIGHT, 1'b0);
    mv(MOVE_RIGHT, 1'b0);
    mv(MOVE_DOWN, 1'b1);
    check_main("short", 1, 2, 3, 1'b0, 1'b0, 1'b1);

    // Restart wins over a simultaneous move.
    do_start();
    for (int i = 0; i < 3; i++) mv(MOVE_RIGHT, 1'b0);
    check_main("pre_restart", 0, 3, 3, 1'b1, 1'b0, 1'b0);
    start      = 1'b1;
    move_valid = 1'b1;
    move_in    = MOVE_RIGHT;
    @(negedge clk);
    start      = 1'b0;
    move_valid = 1'b0;
    check_main("restart_prio", 0, 0, 0, 1'b1, 1'b0, 1'b0);
    mv(MOVE_RIGHT, 1'b0);
    check_main("after_restart", 0, 1, 1, 1'b1, 1'b0, 1'b0);

    // Step overflow on the 3-bit counter instance.
    do_start();
    for (int i = 0; i < 4; i++) begin
      mv(MOVE_RIGHT, 1'b0);
      mv(MOVE_LEFT, 1'b0);
    end
    check("ov.error", 32'(ov_error), 32'd1);
    check("ov.cnt", 32'(ov_step_cnt), 32'd7);
    check("ov.arrived", 32'(ov_arrived), 32'd0);
    check("ov.busy", 32'(ov_busy), 32'd0);
    check("ov.ready", 32'(ov_move_ready), 32'd0);
    check_main("no_ov_wide", 0, 0, 8, 1'b1, 1'b0, 1'b0);

    // Reset mid-path, with a move presented on the reset edge.
    do_start();
    mv(MOVE_RIGHT, 1'b0);
    mv(MOVE_DOWN, 1'b0);
    check_main("pre_rst", 1, 1, 2, 1'b1, 1'b0, 1'b0);
    rst        = 1'b1;
    move_valid = 1'b1;
    move_in    = MOVE_RIGHT;
    @(negedge clk);
    rst        = 1'b0;
    move_valid = 1'b0;
    check_main("mid_rst", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Reset beats start on the same edge.
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check_main("rst_vs_start", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
